concat_writer: RTL and testbench



---
 rtl/concat_writer_pkg.sv | 18 +
 rtl/concat_writer.sv | 142 ++++++++++++++
 tb/tb_concat_writer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/concat_writer_pkg.sv
// Shared LSTM constants and the concat-writer FSM state encoding.
// Imported by concat_writer.
package concat_writer_pkg;

    localparam int unsigned DefaultDataWidth  = 16;
    localparam int unsigned DefaultAddrWidth  = 8;
    localparam int unsigned DefaultInputSize  = 136;
    localparam int unsigned DefaultHiddenSize = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLoadX,
        StLoadH,
        StZeroH,
        StFinish
    } cw_state_e;

endpackage

// File: rtl/concat_writer.sv
// Assembles one [x_t ; h_(t-1)] concat vector into memory, one registered write per element.
// Define CONCAT_ZERO_HIDDEN_EN to write zeros for h on vectors started with first_step=1.
module concat_writer
    import concat_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
    parameter int unsigned INPUT_SIZE  = DefaultInputSize,
    parameter int unsigned HIDDEN_SIZE = DefaultHiddenSize
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         first_step,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    output logic                         x_ready,
    input  logic                         h_valid,
    input  logic signed [DATA_WIDTH-1:0] h_data,
    output logic                         h_ready,
    output logic                         mem_write_enable,
    output logic        [ADDR_WIDTH-1:0] mem_write_address,
    output logic signed [DATA_WIDTH-1:0] mem_write_data,
    output logic                         busy,
    output logic                         done
);

`ifdef CONCAT_ZERO_HIDDEN_EN
    localparam bit ZeroHiddenEn = 1'b1;
`else
    localparam bit ZeroHiddenEn = 1'b0;
`endif

    // The counter runs across both segments, so it is the write address directly.
    localparam logic [ADDR_WIDTH-1:0] LastX = ADDR_WIDTH'(INPUT_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LastH = ADDR_WIDTH'(INPUT_SIZE + HIDDEN_SIZE - 1);

    cw_state_e                    r_state;
    cw_state_e                    w_state_d;
    logic        [ADDR_WIDTH-1:0] r_count;
    logic        [ADDR_WIDTH-1:0] w_count_d;
    logic                         r_first_step;
    logic                         w_first_step_d;
    logic                         r_we;
    logic                         w_we_d;
    logic        [ADDR_WIDTH-1:0] r_addr;
    logic        [ADDR_WIDTH-1:0] w_addr_d;
    logic signed [DATA_WIDTH-1:0] r_data;
    logic signed [DATA_WIDTH-1:0] w_data_d;
    logic                         w_zero_sel;

    assign w_zero_sel = ZeroHiddenEn && r_first_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_first_step <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_first_step <= w_first_step_d;
            r_we         <= w_we_d;
            r_addr       <= w_addr_d;
            r_data       <= w_data_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_first_step_d = r_first_step;
        w_we_d         = 1'b0;
        w_addr_d       = r_addr;
        w_data_d       = r_data;
        x_ready        = 1'b0;
        h_ready        = 1'b0;
        busy           = (r_state != StIdle);
        done           = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_first_step_d = first_step;
                    w_count_d      = '0;
                    w_state_d      = StLoadX;
                end
            end
            StLoadX: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    w_we_d    = 1'b1;
                    w_addr_d  = r_count;
                    w_data_d  = x_data;
                    w_count_d = r_count + 1'b1;
                    if (r_count == LastX) begin
                        w_state_d = w_zero_sel ? StZeroH : StLoadH;
                    end
                end
            end
            StLoadH: begin
                h_ready = 1'b1;
                if (h_valid) begin
                    w_we_d    = 1'b1;
                    w_addr_d  = r_count;
                    w_data_d  = h_data;
                    w_count_d = r_count + 1'b1;
                    if (r_count == LastH) begin
                        w_state_d = StFinish;
                    end
                end
            end
            StZeroH: begin
                w_we_d    = 1'b1;
                w_addr_d  = r_count;
                w_data_d  = '0;
                w_count_d = r_count + 1'b1;
                if (r_count == LastH) begin
                    w_state_d = StFinish;
                end
            end
            StFinish: begin
                // First FINISH cycle carries the last strobe; done follows one cycle later.
                if (!r_we) begin
                    done      = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign mem_write_enable  = r_we;
    assign mem_write_address = r_addr;
    assign mem_write_data    = r_data;

endmodule

// File: tb/tb_concat_writer.sv
// Directed self-checking bench for concat_writer; honours CONCAT_ZERO_HIDDEN_EN if defined.
module tb_concat_writer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NX = 136;
    localparam int NH = 64;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 first_step;
    logic                 x_valid;
    logic signed [DW-1:0] x_data;
    logic                 x_ready;
    logic                 h_valid;
    logic signed [DW-1:0] h_data;
    logic                 h_ready;
    logic                 mem_write_enable;
    logic        [AW-1:0] mem_write_address;
    logic signed [DW-1:0] mem_write_data;
    logic                 busy;
    logic                 done;

    concat_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INPUT_SIZE (NX),
        .HIDDEN_SIZE(NH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .first_step       (first_step),
        .x_valid          (x_valid),
        .x_data           (x_data),
        .x_ready          (x_ready),
        .h_valid          (h_valid),
        .h_data           (h_data),
        .h_ready          (h_ready),
        .mem_write_enable (mem_write_enable),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .busy             (busy),
        .done             (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Write log captured on the falling edge, away from the active edge.
    logic        [AW-1:0] wa[$];
    logic signed [DW-1:0] wd[$];
    int                   wc[$];
    int                   cyc       = 0;
    int                   n_done    = 0;
    int                   done_cyc  = -1;
    int                   both_rdy  = 0;
    int                   h_rdy_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_write_enable) begin
            wa.push_back(mem_write_address);
            wd.push_back(mem_write_data);
            wc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (x_ready && h_ready) both_rdy++;
        if (h_ready) h_rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        n_done    = 0;
        done_cyc  = -1;
        h_rdy_cnt = 0;
    endtask

    task automatic start_vec(input logic fs);
        start      = 1'b1;
        first_step = fs;
        step();
        start      = 1'b0;
        first_step = 1'b0;
    endtask

    task automatic send_x(input int v);
        int n;
        n       = 0;
        x_valid = 1'b1;
        x_data  = DW'(v);
        while (!x_ready && n < 100) begin
            step();
            n++;
        end
        check("x_ready_wait", 32'(x_ready), 32'd1);
        step();
        x_valid = 1'b0;
    endtask

    task automatic send_h(input int v);
        int n;
        n       = 0;
        h_valid = 1'b1;
        h_data  = DW'(v);
        while (!h_ready && n < 100) begin
            step();
            n++;
        end
        check("h_ready_wait", 32'(h_ready), 32'd1);
        step();
        h_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n_done == 0 && n < 500) begin
            step();
            n++;
        end
        check("done_seen", 32'(n_done), 32'd1);
        step();
    endtask

    // Full-vector check: addresses 0..199, x data k+1, h data -(j+1) or 0, done after last write.
    task automatic check_vector(input string tag, input bit zero_h);
        int nerr;
        nerr = 0;
        check({tag, "_nwrites"}, 32'(wa.size()), 32'(NX + NH));
        if (wa.size() == NX + NH) begin
            for (int i = 0; i < NX + NH; i++) begin
                int e;
                e = (i < NX) ? i + 1 : (zero_h ? 0 : -(i - NX + 1));
                if (wa[i] !== AW'(i) || wd[i] !== DW'(e)) nerr++;
            end
            check({tag, "_addr_data_errs"}, 32'(nerr), 32'd0);
            check({tag, "_done_lat"}, 32'(done_cyc - wc[NX + NH - 1]), 32'd1);
        end
        check({tag, "_ndone"}, 32'(n_done), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        first_step = 1'b0;
        x_valid    = 1'b0;
        x_data     = '0;
        h_valid    = 1'b0;
        h_data     = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x_ready", 32'(x_ready), 32'd0);
        check("rst_h_ready", 32'(h_ready), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", 32'(mem_write_address), 32'd0);
        check("rst_data", 32'(mem_write_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back x then h.
        clear_log();
        start_vec(1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < NX; k++) send_x(k + 1);
        for (int j = 0; j < NH; j++) send_h(-(j + 1));
        wait_done();
        check_vector("t1", 1'b0);
        if (wc.size() == NX + NH) check("t1_contig", 32'(wc[NX + NH - 1] - wc[0]), 32'(NX + NH - 1));

        // x_valid every other cycle.
        clear_log();
        start_vec(1'b0);
        for (int k = 0; k < NX; k++) begin
            send_x(k + 1);
            step();
        end
        step();
        check("t2_nx", 32'(wa.size()), 32'(NX));
        if (wa.size() == NX) begin
            int gerr;
            gerr = 0;
            for (int k = 0; k < NX - 1; k++) if (wc[k + 1] - wc[k] != 2) gerr++;
            check("t2_gap_errs", 32'(gerr), 32'd0);
            check("t2_last_addr", 32'(wa[NX - 1]), 32'(NX - 1));
        end
        for (int j = 0; j < NH; j++) send_h(-(j + 1));
        wait_done();
        check_vector("t2", 1'b0);

        // first_step=1 vector.
        clear_log();
        h_valid = 1'b1;
        h_data  = 16'sd9;
        start_vec(1'b1);
        for (int k = 0; k < NX; k++) send_x(k + 1);
`ifdef CONCAT_ZERO_HIDDEN_EN
        wait_done();
        h_valid = 1'b0;
        check_vector("t3z", 1'b1);
        check("t3z_h_ready_seen", 32'(h_rdy_cnt), 32'd0);
        if (wc.size() == NX + NH) check("t3z_contig", 32'(wc[NX + NH - 1] - wc[NX]), 32'(NH - 1));
`else
        h_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t3_wait_nwrites", 32'(wa.size()), 32'(NX));
        check("t3_wait_h_ready", 32'(h_ready), 32'd1);
        check("t3_wait_busy", 32'(busy), 32'd1);
        for (int j = 0; j < NH; j++) send_h(-(j + 1));
        wait_done();
        check_vector("t3", 1'b0);
`endif

        // Reset after 70 x beats.
        clear_log();
        start_vec(1'b0);
        for (int k = 0; k < 70; k++) send_x(k + 1);
        rst_n = 1'b0;
        #1;
        check("t4_busy_now", 32'(busy), 32'd0);
        check("t4_we_now", 32'(mem_write_enable), 32'd0);
        check("t4_x_ready_now", 32'(x_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t4_no_done", 32'(n_done), 32'd0);
        clear_log();
        start_vec(1'b0);
        for (int k = 0; k < NX; k++) send_x(k + 1);
        for (int j = 0; j < NH; j++) send_h(-(j + 1));
        wait_done();
        check_vector("t4", 1'b0);

        // h_valid held during LOAD_X, start held during LOAD_H.
        clear_log();
        h_valid = 1'b1;
        h_data  = 16'sd7;
        start_vec(1'b0);
        for (int k = 0; k < NX; k++) send_x(k + 1);
        h_valid = 1'b0;
        step();
        check("t5_nx", 32'(wa.size()), 32'(NX));
        start = 1'b1;
        for (int j = 0; j < NH; j++) send_h(-(j + 1));
        start = 1'b0;
        wait_done();
        check_vector("t5", 1'b0);

        check("never_both_ready", 32'(both_rdy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
